// File: rtl/axi2apb_pkg.sv
// Shared types and constants for the AXI4-Lite-to-APB request controller.
// Holds the controller FSM encoding, AXI response codes and the APB master state codes.
package axi2apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_XFER,
        ST_RD_XFER,
        ST_WR_RESP,
        ST_RD_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] APB_ST_IDLE   = 2'd0;
    localparam logic [1:0] APB_ST_SETUP  = 2'd1;
    localparam logic [1:0] APB_ST_ACCESS = 2'd2;

    // The APB transfer completes in the Access cycle where the slave is ready.
    function automatic logic apb_done(input logic [1:0] m_state, input logic pready);
        return (m_state == APB_ST_ACCESS) && pready;
    endfunction

endpackage

// File: rtl/axi2apb_hold1.sv
// One-deep valid/ready holding register used for the AW, W and AR channels.
// The slot stays full until the controller grants the transfer that uses it.
module axi2apb_hold1 #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_clr,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;
    logic         w_load;

    // Ready is held low until the first clock after reset so every output reads 0 in reset.
    assign o_ready = ~r_full & i_en;
    assign w_load  = i_valid & o_ready;
    assign o_full  = r_full;
    assign o_data  = r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end else if (w_load) begin
            r_full <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_load) begin
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/axi4lite_apb_req_ctrl.sv
// AXI4-Lite slave front-end of the AXI4-Lite-to-APB bridge: one outstanding APB transfer at a time.
// Optional AXI2APB_SLVERR_EN: report PSLVERR and partial-strobe writes as SLVERR responses.
module axi4lite_apb_req_ctrl
    import axi2apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RVALID,
    input  logic                RREADY,
    output logic                STREQ,
    output logic                SWRT,
    output logic                SSEL,
    output logic [ADDR_W-1:0]   SADDR,
    output logic [DATA_W-1:0]   SWDATA,
    input  logic [DATA_W-1:0]   SRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR,
    input  logic [1:0]          M_STATE
);

    localparam int STRB_W = DATA_W / 8;

    state_t                     r_state;
    logic                       r_last_rd;
    logic                       r_en;
    logic [ADDR_W-1:0]          r_saddr;
    logic [DATA_W-1:0]          r_swdata;
    logic [DATA_W-1:0]          r_rdata;
    logic [1:0]                 r_bresp;
    logic [1:0]                 r_rresp;

    logic                       w_aw_full;
    logic [ADDR_W-1:0]          w_aw_data;
    logic                       w_w_full;
    logic [DATA_W+STRB_W-1:0]   w_w_data;
    logic                       w_ar_full;
    logic [ADDR_W-1:0]          w_ar_data;
    logic                       w_wr_ok;
    logic                       w_rd_ok;
    logic                       w_grant_wr;
    logic                       w_grant_rd;
    logic                       w_xfer;
    logic                       w_done;
    logic                       w_strb_err;
    logic [1:0]                 w_apb_resp;

    axi2apb_hold1 #(.W(ADDR_W)) u_aw (
        .i_clk(PCLK), .i_rst_n(PRESETn), .i_en(r_en),
        .i_data(AWADDR), .i_valid(AWVALID), .o_ready(AWREADY),
        .i_clr(w_grant_wr), .o_full(w_aw_full), .o_data(w_aw_data)
    );

    axi2apb_hold1 #(.W(DATA_W + STRB_W)) u_w (
        .i_clk(PCLK), .i_rst_n(PRESETn), .i_en(r_en),
        .i_data({WDATA, WSTRB}), .i_valid(WVALID), .o_ready(WREADY),
        .i_clr(w_grant_wr), .o_full(w_w_full), .o_data(w_w_data)
    );

    axi2apb_hold1 #(.W(ADDR_W)) u_ar (
        .i_clk(PCLK), .i_rst_n(PRESETn), .i_en(r_en),
        .i_data(ARADDR), .i_valid(ARVALID), .o_ready(ARREADY),
        .i_clr(w_grant_rd), .o_full(w_ar_full), .o_data(w_ar_data)
    );

    // On a tie the channel not served last wins, so reads and writes alternate under load.
    assign w_wr_ok    = w_aw_full & w_w_full;
    assign w_rd_ok    = w_ar_full;
    assign w_grant_wr = (r_state == ST_IDLE) & w_wr_ok & (~w_rd_ok | r_last_rd);
    assign w_grant_rd = (r_state == ST_IDLE) & w_rd_ok & ~w_grant_wr;

    assign w_xfer = (r_state == ST_WR_XFER) || (r_state == ST_RD_XFER);
    assign w_done = apb_done(M_STATE, PREADY);

`ifdef AXI2APB_SLVERR_EN
    assign w_strb_err = (w_w_data[STRB_W-1:0] != {STRB_W{1'b1}});
    assign w_apb_resp = PSLVERR ? RESP_SLVERR : RESP_OKAY;
`else
    logic w_unused;
    assign w_unused   = ^{w_w_data[STRB_W-1:0], PSLVERR};
    assign w_strb_err = 1'b0;
    assign w_apb_resp = RESP_OKAY;
`endif

    // STREQ falls in the completion cycle so the APB master goes straight back to Idle.
    assign STREQ  = w_xfer & ~w_done;
    assign SSEL   = w_xfer;
    assign SWRT   = (r_state == ST_WR_XFER);
    assign SADDR  = r_saddr;
    assign SWDATA = r_swdata;
    assign BVALID = (r_state == ST_WR_RESP);
    assign BRESP  = r_bresp;
    assign RVALID = (r_state == ST_RD_RESP);
    assign RDATA  = r_rdata;
    assign RRESP  = r_rresp;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= ST_IDLE;
            r_last_rd <= 1'b1;
            r_en      <= 1'b0;
            r_saddr   <= '0;
            r_swdata  <= '0;
            r_rdata   <= '0;
            r_bresp   <= RESP_OKAY;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_en <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_wr) begin
                        r_saddr   <= w_aw_data;
                        r_swdata  <= w_w_data[STRB_W +: DATA_W];
                        r_last_rd <= 1'b0;
                        // A partial-strobe write is refused without touching the APB bus.
                        if (w_strb_err) begin
                            r_bresp <= RESP_SLVERR;
                            r_state <= ST_WR_RESP;
                        end else begin
                            r_state <= ST_WR_XFER;
                        end
                    end else if (w_grant_rd) begin
                        r_saddr   <= w_ar_data;
                        r_last_rd <= 1'b1;
                        r_state   <= ST_RD_XFER;
                    end
                end
                ST_WR_XFER: begin
                    if (w_done) begin
                        r_bresp <= w_apb_resp;
                        r_state <= ST_WR_RESP;
                    end
                end
                ST_RD_XFER: begin
                    if (w_done) begin
                        r_rdata <= SRDATA;
                        r_rresp <= w_apb_resp;
                        r_state <= ST_RD_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (BREADY) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD_RESP: begin
                    if (RREADY) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_apb_req_ctrl.sv
// Directed bench for axi4lite_apb_req_ctrl with a small behavioural APB master.
// Honours AXI2APB_SLVERR_EN when the same macro is defined for the build.
module tb_axi4lite_apb_req_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA, SADDR, SWDATA, SRDATA;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP, M_STATE;
    logic        STREQ, SWRT, SSEL, PREADY, PSLVERR;

    int n_chk = 0;
    int n_err = 0;
    int wait_cfg = 0;
    int m_wait;
    int base;

    logic [31:0] log_addr [0:31];
    logic        log_wr   [0:31];
    int          log_n = 0;
    logic        prev_req = 1'b0;

    axi4lite_apb_req_ctrl dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .STREQ(STREQ), .SWRT(SWRT), .SSEL(SSEL), .SADDR(SADDR), .SWDATA(SWDATA),
        .SRDATA(SRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .M_STATE(M_STATE)
    );

    always #5 PCLK = ~PCLK;

    // APB master: Idle -> Setup on STREQ, Setup -> Access, Access holds for wait_cfg cycles.
    assign PREADY = (M_STATE == 2'd2) && (m_wait == 0);
    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            M_STATE <= 2'd0;
            m_wait  <= 0;
        end else begin
            case (M_STATE)
                2'd0: if (STREQ) M_STATE <= 2'd1;
                2'd1: begin M_STATE <= 2'd2; m_wait <= wait_cfg; end
                default: if (m_wait == 0) M_STATE <= 2'd0; else m_wait <= m_wait - 1;
            endcase
        end
    end

    // Log every transfer start (rising STREQ).
    always @(negedge PCLK) begin
        if (STREQ && !prev_req && log_n < 32) begin
            log_addr[log_n] <= SADDR;
            log_wr[log_n]   <= SWRT;
            log_n           <= log_n + 1;
        end
        prev_req <= STREQ;
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic do_aw, input logic do_w, input logic do_ar,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] ra);
        logic rdy;
        AWADDR = a; WDATA = d; WSTRB = s; ARADDR = ra;
        AWVALID = do_aw; WVALID = do_w; ARVALID = do_ar;
        rdy = (!do_aw || AWREADY) && (!do_w || WREADY) && (!do_ar || ARREADY);
        for (int i = 0; i < 60 && !rdy; i++) begin
            step();
            rdy = (!do_aw || AWREADY) && (!do_w || WREADY) && (!do_ar || ARREADY);
        end
        chk("push_ready", 32'(rdy), 1);
        step();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    endtask

    task automatic wait_b();
        for (int i = 0; i < 60 && BVALID !== 1'b1; i++) step();
        chk("bvalid_wait", 32'(BVALID), 1);
    endtask

    task automatic wait_r();
        for (int i = 0; i < 60 && RVALID !== 1'b1; i++) step();
        chk("rvalid_wait", 32'(RVALID), 1);
    endtask

    task automatic ack_b();
        BREADY = 1'b1; step(); BREADY = 1'b0;
    endtask

    task automatic ack_r();
        RREADY = 1'b1; step(); RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_addr [0:3];
        logic        exp_wr   [0:3];
        PRESETn = 1'b0;
        AWADDR = '0; WDATA = '0; WSTRB = '0; ARADDR = '0; SRDATA = 32'h1234_5678;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        BREADY = 1'b0; RREADY = 1'b0; PSLVERR = 1'b0;
        #2;
        chk("rst_outputs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, STREQ, SSEL, SWRT, BRESP, RRESP}, 0);
        chk("rst_saddr", SADDR, 0);
        step(); step();
        PRESETn = 1'b1;
        step();
        chk("ready_after_rst", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Test 1: AW+W together, exact latency
        AWADDR = 32'h10; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("t1_n1_streq", 32'(STREQ), 0);
        chk("t1_n1_ready", {AWREADY, WREADY}, 0);
        step();
        chk("t1_n2_streq", 32'(STREQ), 1);
        chk("t1_n2_swrt_ssel", {SWRT, SSEL}, 2'b11);
        chk("t1_saddr", SADDR, 32'h10);
        chk("t1_swdata", SWDATA, 32'hDEAD_BEEF);
        step();
        chk("t1_n3_setup", {M_STATE, STREQ}, 3'b011);
        step();
        chk("t1_n4_done", {M_STATE, STREQ, BVALID}, 4'b1000);
        step();
        chk("t1_n5_bvalid", 32'(BVALID), 1);
        chk("t1_bresp", BRESP, 0);
        ack_b();
        chk("t1_b_done", 32'(BVALID), 0);
        chk("t1_idle_hold", {STREQ, SSEL, SWRT, SADDR}, {3'b000, 32'h10});

        // Test 3: W two cycles ahead of AW
        push(1'b0, 1'b1, 1'b0, 32'h0, 32'h0BAD_F00D, 4'hF, 32'h0);
        chk("t3_wready_low", 32'(WREADY), 0);
        step();
        chk("t3_no_req_a", 32'(STREQ), 0);
        step();
        chk("t3_no_req_b", 32'(STREQ), 0);
        base = log_n;
        push(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 4'h0, 32'h0);
        wait_b();
        chk("t3_addr", log_addr[base], 32'h44);
        chk("t3_wr", 32'(log_wr[base]), 1);
        chk("t3_swdata", SWDATA, 32'h0BAD_F00D);
        ack_b();
        step(); step(); step();
        chk("t3_single", log_n - base, 1);

        // Test 2: read with three Access wait cycles
        wait_cfg = 3;
        push(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h20);
        step();
        chk("t2_req", {STREQ, SWRT, SADDR}, {2'b10, 32'h20});
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_held", {STREQ, SADDR}, {1'b1, 32'h20});
        end
        step();
        chk("t2_done", {PREADY, STREQ}, 2'b10);
        step();
        chk("t2_rvalid", {RVALID, RRESP}, 3'b100);
        chk("t2_rdata", RDATA, 32'h1234_5678);
        step();
        chk("t2_rstable", {RVALID, RDATA}, {1'b1, 32'h1234_5678});
        ack_r();
        chk("t2_r_done", 32'(RVALID), 0);

        // Test 4: write/read ties, twice, auto-accepted responses
        wait_cfg = 1;
        BREADY = 1'b1; RREADY = 1'b1;
        base = log_n;
        push(1'b1, 1'b1, 1'b1, 32'h100, 32'hA1, 4'hF, 32'h200);
        push(1'b1, 1'b1, 1'b0, 32'h104, 32'hA2, 4'hF, 32'h0);
        push(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h204);
        for (int i = 0; i < 200 && (log_n - base) < 4; i++) step();
        for (int i = 0; i < 12; i++) step();
        BREADY = 1'b0; RREADY = 1'b0;
        chk("t4_count", log_n - base, 4);
        exp_addr[0] = 32'h100; exp_addr[1] = 32'h200; exp_addr[2] = 32'h104; exp_addr[3] = 32'h204;
        exp_wr[0] = 1'b1; exp_wr[1] = 1'b0; exp_wr[2] = 1'b1; exp_wr[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_xfer%0d", k), {log_wr[base + k], log_addr[base + k]}, {exp_wr[k], exp_addr[k]});
        end
        chk("t4_idle", {BVALID, RVALID, STREQ}, 0);

        // Test 5: slave error / partial strobes
        wait_cfg = 0;
        PSLVERR = 1'b1;
        push(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h500);
        wait_r();
`ifdef AXI2APB_SLVERR_EN
        chk("t5_rresp", RRESP, 2'b10);
`else
        chk("t5_rresp", RRESP, 2'b00);
`endif
        ack_r();
        PSLVERR = 1'b0;
        base = log_n;
        push(1'b1, 1'b1, 1'b0, 32'h600, 32'h0000_0066, 4'b0011, 32'h0);
        wait_b();
`ifdef AXI2APB_SLVERR_EN
        chk("t5_bresp", BRESP, 2'b10);
        chk("t5_no_apb", log_n - base, 0);
`else
        chk("t5_bresp", BRESP, 2'b00);
        chk("t5_apb", log_n - base, 1);
`endif
        ack_b();

        // Test 6: reset during Access
        wait_cfg = 3;
        push(1'b1, 1'b1, 1'b0, 32'h300, 32'h55, 4'hF, 32'h0);
        for (int i = 0; i < 20 && M_STATE !== 2'd2; i++) step();
        chk("t6_in_access", M_STATE, 2);
        #1;
        PRESETn = 1'b0;
        #1;
        chk("t6_ctrl_zero", {AWREADY, WREADY, ARREADY, BVALID, RVALID, STREQ, SSEL, SWRT}, 0);
        chk("t6_bus_zero", {SADDR, SWDATA}, 0);
        step(); step();
        PRESETn = 1'b1;
        wait_cfg = 0;
        step();
        chk("t6_no_resp", {BVALID, RVALID, STREQ}, 0);
        base = log_n;
        push(1'b1, 1'b1, 1'b0, 32'h400, 32'h77, 4'hF, 32'h0);
        wait_b();
        chk("t6_bresp", BRESP, 0);
        chk("t6_addr", log_addr[base], 32'h400);
        chk("t6_swdata", SWDATA, 32'h77);
        ack_b();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
